// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e      : receiver FSM state encoding
//   PAR_EVEN/ODD    : parity type selector values
//   PRESCALE_8/16/32: legal oversampling ratios
//   majority3       : 2-of-3 vote used for bit decisions
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: counts clk cycles inside a bit,
// captures the line around mid-bit and resolves the bit by majority vote.
//   clk, reset_n : clock, async active-low reset
//   active       : a frame is in progress; counter is held at 0 otherwise
//   rx_s         : synchronized serial line
//   prescale     : captured clk cycles per bit
//   sampled_bit  : majority of the three mid-bit captures
//   bit_end      : high on the last cycle of the current bit
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       active,
    input  logic       rx_s,
    input  logic [5:0] prescale,
    output logic       sampled_bit,
    output logic       bit_end
);

    logic [5:0] edge_cnt_r;
    logic [5:0] half_s;
    logic [5:0] last_s;
    logic       samp0_r;
    logic       samp1_r;
    logic       bit_r;

    assign half_s = {1'b0, prescale[5:1]};
    // A zero prescale wraps to 63 here, so every bit still ends within 64 cycles.
    assign last_s = prescale - 6'd1;

    assign bit_end     = active && (edge_cnt_r == last_s);
    assign sampled_bit = bit_r;

    // Edge counter: 0..P-1 within each bit, parked at 0 while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt_r <= 6'd0;
        end else if (!active) begin
            edge_cnt_r <= 6'd0;
        end else if (edge_cnt_r == last_s) begin
            edge_cnt_r <= 6'd0;
        end else begin
            edge_cnt_r <= edge_cnt_r + 6'd1;
        end
    end

    // Mid-bit captures; the third capture resolves the vote in the same cycle,
    // so the decision is ready well before the bit-end cycle consumes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp0_r <= 1'b1;
            samp1_r <= 1'b1;
            bit_r   <= 1'b1;
        end else if (active) begin
            if (edge_cnt_r == half_s - 6'd1) samp0_r <= rx_s;
            if (edge_cnt_r == half_s)        samp1_r <= rx_s;
            if (edge_cnt_r == half_s + 6'd1) bit_r   <= majority3(samp0_r, samp1_r, rx_s);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: idle-high line, 1 start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, 1 stop bit. Oversampled by a runtime prescale.
//   clk, reset_n : clock, async active-low reset
//   rx_in        : asynchronous serial input
//   par_en       : frame carries a parity bit
//   par_typ      : 0 even, 1 odd parity
//   prescale     : clk cycles per bit (8, 16 or 32)
//   p_data       : last good word, held until the next good frame
//   data_valid   : 1-cycle strobe, p_data updated
//   par_err      : 1-cycle strobe, parity mismatch
//   stp_err      : 1-cycle strobe, stop bit sampled 0
//   busy         : frame in progress
// DATA_WIDTH must be at least 2.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            prescale,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                  rx_meta_r;
    logic                  rx_s;
    rx_state_e             state_r;
    rx_state_e             next_s;
    logic                  illegal_s;
    logic [5:0]            prescale_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_flag_r;
    logic                  sampled_bit_s;
    logic                  bit_end_s;
    logic                  start_det_s;
    logic                  prescale_ok_s;
    logic                  exp_par_s;

    assign start_det_s   = (state_r == IDLE) && !rx_s;
    assign prescale_ok_s = (prescale == PRESCALE_8) || (prescale == PRESCALE_16) ||
                           (prescale == PRESCALE_32);
    assign exp_par_s     = (^shift_r) ^ (par_typ_r == PAR_ODD);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_s      <= rx_meta_r;
        end
    end

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .reset_n     (reset_n),
        .active      (state_r != IDLE),
        .rx_s        (rx_s),
        .prescale    (prescale_r),
        .sampled_bit (sampled_bit_s),
        .bit_end     (bit_end_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_s    = state_r;
        illegal_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) next_s = START;
                else       next_s = IDLE;
            end
            START: begin
                if (bit_end_s) next_s = sampled_bit_s ? IDLE : DATA;
                else           next_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_cnt_r == LAST_BIT)) next_s = par_en_r ? PARITY : STOP;
                else                                      next_s = DATA;
            end
            PARITY: begin
                if (bit_end_s) next_s = STOP;
                else           next_s = PARITY;
            end
            STOP: begin
                if (bit_end_s) next_s = IDLE;
                else           next_s = STOP;
            end
            default: begin
                next_s    = IDLE;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Frame configuration capture, bit counter, deserializer and parity flag.
    // Prescale values outside 8/16/32 fall back to 16 so bit timing stays bounded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_r <= 6'd0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            bit_cnt_r  <= {CNT_W{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            par_flag_r <= 1'b0;
        end else if (start_det_s) begin
            prescale_r <= prescale_ok_s ? prescale : PRESCALE_16;
            par_en_r   <= par_en;
            par_typ_r  <= par_typ;
            bit_cnt_r  <= {CNT_W{1'b0}};
            par_flag_r <= 1'b0;
        end else if (bit_end_s && (state_r == DATA)) begin
            shift_r   <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end else if (bit_end_s && (state_r == PARITY)) begin
            par_flag_r <= (sampled_bit_s != exp_par_s);
        end
    end

    // Registered outputs: strobes fire on the cycle after the stop-bit end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_data     <= {DATA_WIDTH{1'b0}};
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= (next_s != IDLE);
            if (illegal_s) begin
                p_data <= {DATA_WIDTH{1'b0}};
            end else if ((state_r == STOP) && bit_end_s) begin
                stp_err <= !sampled_bit_s;
                par_err <= par_flag_r;
                if (sampled_bit_s && !par_flag_r) begin
                    data_valid <= 1'b1;
                    p_data     <= shift_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
module tb_uart_rx;

    logic       clk;
    logic       reset_n;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process)
    int       dv_cnt = 0;
    int       pe_cnt = 0;
    int       se_cnt = 0;
    int       busy_cnt = 0;
    int       width_err = 0;
    logic [7:0] dv_data [0:63];
    logic     dv_prev = 1'b0;
    logic     pe_prev = 1'b0;
    logic     se_prev = 1'b0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_data[dv_cnt % 64] <= p_data;
            dv_cnt <= dv_cnt + 1;
        end
        if (par_err) pe_cnt <= pe_cnt + 1;
        if (stp_err) se_cnt <= se_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if ((data_valid && dv_prev) || (par_err && pe_prev) || (stp_err && se_prev))
            width_err <= width_err + 1;
        dv_prev <= data_valid;
        pe_prev <= par_err;
        se_prev <= stp_err;
    end

    task automatic send_bit(input logic b, input int p);
        rx_in = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (with_par) send_bit(par_bit, p);
        send_bit(stop_bit, p);
        rx_in = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_in = 1'b1;
        par_en = 1'b0;
        par_typ = 1'b0;
        prescale = 6'd8;
        repeat (3) @(negedge clk);
        checks++;
        if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h expected 00", p_data); end
        checks++;
        if ({data_valid, par_err, stp_err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {data_valid, par_err, stp_err, busy});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic_p8();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt, b0 = busy_cnt;
        prescale = 6'd8; par_en = 1'b0;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL p8_dv_count: got %0d expected 1", dv_cnt - dv0); end
        checks++;
        if (dv_data[dv0 % 64] !== 8'h55) begin errors++; $display("FAIL p8_data: got %h expected 55", dv_data[dv0 % 64]); end
        checks++;
        if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
            errors++; $display("FAIL p8_no_err: got %0d error strobes expected 0", (pe_cnt - pe0) + (se_cnt - se0));
        end
        checks++;
        if (busy_cnt - b0 !== 80) begin errors++; $display("FAIL p8_busy_len: got %0d expected 80", busy_cnt - b0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL p8_busy_low: got %b expected 0", busy); end
    endtask

    task automatic test_parity_even();
        int dv0 = dv_cnt, pe0 = pe_cnt;
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        // 0xA3 has four ones: even parity bit is 0
        send_frame(8'hA3, 16, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL par_good_dv: got %0d expected 1", dv_cnt - dv0); end
        checks++;
        if (p_data !== 8'hA3) begin errors++; $display("FAIL par_good_data: got %h expected a3", p_data); end
        checks++;
        if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL par_good_noerr: got %0d expected 0", pe_cnt - pe0); end
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'hA3, 16, 1'b1, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL par_bad_err: got %0d expected 1", pe_cnt - pe0); end
        checks++;
        if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL par_bad_dv: got %0d expected 0", dv_cnt - dv0); end
        checks++;
        if (p_data !== 8'hA3) begin errors++; $display("FAIL par_bad_hold: got %h expected a3", p_data); end
    endtask

    task automatic test_stop_error();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        prescale = 6'd32; par_en = 1'b1; par_typ = 1'b1;
        // 0x0F has four ones: odd parity bit is 1
        send_frame(8'h0F, 32, 1'b1, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if (se_cnt - se0 !== 1) begin errors++; $display("FAIL stp_err_count: got %0d expected 1", se_cnt - se0); end
        checks++;
        if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL stp_dv: got %0d expected 0", dv_cnt - dv0); end
        checks++;
        if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL stp_par: got %0d expected 0", pe_cnt - pe0); end
        checks++;
        if (p_data !== 8'hA3) begin errors++; $display("FAIL stp_hold: got %h expected a3", p_data); end
    endtask

    task automatic test_glitch();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt, b0 = busy_cnt;
        prescale = 6'd8; par_en = 1'b0;
        send_bit(1'b0, 2);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy_cnt - b0 !== 8) begin errors++; $display("FAIL glitch_start_len: got %0d expected 8", busy_cnt - b0); end
        checks++;
        if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
            errors++; $display("FAIL glitch_strobes: got %0d expected 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int dv0 = dv_cnt;
        logic [7:0] exp [0:2];
        exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF;
        prescale = 6'd16; par_en = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 16, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if (dv_cnt - dv0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", dv_cnt - dv0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dv_data[(dv0 + i) % 64] !== exp[i]) begin
                errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, dv_data[(dv0 + i) % 64], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int dv0;
        logic [7:0] d;
        d = 8'h3C;
        prescale = 6'd16; par_en = 1'b0;
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(d[i], 16);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        reset_n = 1'b0;
        rx_in = 1'b1;
        @(negedge clk);
        checks++;
        if (p_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", p_data); end
        checks++;
        if ({data_valid, par_err, stp_err, busy} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {data_valid, par_err, stp_err, busy});
        end
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        dv0 = dv_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL mid_aborted: got %0d expected 0", dv_cnt - dv0); end
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL mid_after_dv: got %0d expected 1", dv_cnt - dv0); end
        checks++;
        if (p_data !== 8'hC3) begin errors++; $display("FAIL mid_after_data: got %h expected c3", p_data); end
    endtask

    task automatic test_strobe_width();
        checks++;
        if (width_err !== 0) begin errors++; $display("FAIL strobe_width: got %0d wide strobes expected 0", width_err); end
    endtask

    initial begin
        test_reset();
        test_basic_p8();
        test_parity_even();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_strobe_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
